if_id_skid: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush, bubble insertion and a stall-cycle counter. It sits between instruction memory/fetch and decode. It captures the 32-bit instruction word with its PC and presents registered MIPS decode fields from the head entry. Back-pressure from decode does not combinationally reach fetch.

---
 rtl/if_id_skid.sv | 139 +++++++++++++
 tb/tb_if_id_skid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage: two-entry skid buffer between fetch and decode.
// Presents registered MIPS decode fields from the head entry and counts
// stalled cycles. in_ready depends only on registered occupancy, so decode
// back-pressure never reaches fetch combinationally.
module if_id_skid #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             reloj,
    input  logic             resetIF_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic [31:0]      imm_sext,
    output logic [25:0]      jump_addr,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             clr_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [31:0]       head_instr_q, head_instr_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic pop;

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy and entry next-state; flush discards everything, including the incoming beat.
    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                    end else if (accept) begin
                        state_d      = StTwo;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d      = StOne;
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and entry registers with asynchronous reset.
    always_ff @(posedge reloj or negedge resetIF_n) begin
        if (!resetIF_n) begin
            state_q      <= StEmpty;
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            cnt_q        <= cnt_d;
        end
    end

    // Head entry is stale once popped, so gate it with occupancy.
    assign out_instr = out_valid ? head_instr_q : NOP_INSTR;
    assign out_pc    = out_valid ? head_pc_q : '0;
    assign stall_cnt = cnt_q;

    assign opcode    = out_instr[31:26];
    assign rs        = out_instr[25:21];
    assign rt        = out_instr[20:16];
    assign rd        = out_instr[15:11];
    assign shamt     = out_instr[10:6];
    assign funct     = out_instr[5:0];
    assign imm       = out_instr[15:0];
    assign imm_sext  = {{16{out_instr[15]}}, out_instr[15:0]};
    assign jump_addr = out_instr[25:0];

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid with a FIFO scoreboard of accepted beats.
module tb_if_id_skid;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic             reloj;
    logic             resetIF_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic [31:0]      imm_sext;
    logic [25:0]      jump_addr;
    logic [CNT_W-1:0] stall_cnt;
    logic             clr_cnt;

    if_id_skid #(
        .PC_W      (PC_W),
        .CNT_W     (CNT_W),
        .NOP_INSTR (NOP)
    ) dut (
        .reloj     (reloj),
        .resetIF_n (resetIF_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .imm_sext  (imm_sext),
        .jump_addr (jump_addr),
        .stall_cnt (stall_cnt),
        .clr_cnt   (clr_cnt)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } beat_t;

    beat_t sb[$];
    int    model_cnt;
    int    errors;
    int    checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then clock one cycle and update the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                        input logic ordy, input logic fl, input logic clr);
        logic [31:0]     e_instr;
        logic [PC_W-1:0] e_pc;
        logic            acc;
        logic            pp;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
        e_instr   = (sb.size() != 0) ? sb[0].instr : NOP;
        e_pc      = (sb.size() != 0) ? sb[0].pc : '0;
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("out_instr", 64'(out_instr), 64'(e_instr));
        chk("out_pc", 64'(out_pc), 64'(e_pc));
        chk("opcode", 64'(opcode), 64'(e_instr[31:26]));
        chk("rs", 64'(rs), 64'(e_instr[25:21]));
        chk("rt", 64'(rt), 64'(e_instr[20:16]));
        chk("rd", 64'(rd), 64'(e_instr[15:11]));
        chk("shamt", 64'(shamt), 64'(e_instr[10:6]));
        chk("funct", 64'(funct), 64'(e_instr[5:0]));
        chk("imm", 64'(imm), 64'(e_instr[15:0]));
        chk("imm_sext", 64'(imm_sext), 64'({{16{e_instr[15]}}, e_instr[15:0]}));
        chk("jump_addr", 64'(jump_addr), 64'(e_instr[25:0]));
        chk("stall_cnt", 64'(stall_cnt), 64'(model_cnt));
        acc = v && (sb.size() < 2);
        pp  = (sb.size() != 0) && ordy;
        @(posedge reloj);
        if (clr) model_cnt = 0;
        else if ((sb.size() != 0) && !ordy && (model_cnt < 15)) model_cnt++;
        if (fl) begin
            sb.delete();
        end else begin
            if (pp) void'(sb.pop_front());
            if (acc) sb.push_back('{instr: ins, pc: pc});
        end
        @(negedge reloj);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        model_cnt = 0;
        resetIF_n = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset values while held in reset.
        @(negedge reloj);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_instr", 64'(out_instr), 64'(NOP));
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        resetIF_n = 1'b1;

        // Stream at full rate.
        step(1'b1, 32'h2002_0005, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("beat1_instr", 64'(out_instr), 64'h2002_0005);
        step(1'b1, 32'h0043_0820, 32'h4, 1'b1, 1'b0, 1'b0);
        chk("beat2_opcode", 64'(opcode), 64'd0);
        chk("beat2_rs", 64'(rs), 64'd2);
        chk("beat2_rt", 64'(rt), 64'd3);
        chk("beat2_rd", 64'(rd), 64'd1);
        chk("beat2_funct", 64'(funct), 64'h20);
        chk("beat2_pc", 64'(out_pc), 64'h4);
        step(1'b1, 32'h0800_0010, 32'h8, 1'b1, 1'b0, 1'b0);
        chk("beat3_jump", 64'(jump_addr), 64'h10);
        step(1'b1, 32'h2001_FFFC, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("neg_imm", 64'(imm), 64'hFFFC);
        chk("neg_sext", 64'(imm_sext), 64'hFFFF_FFFC);
        step(1'b1, 32'h2001_7FFF, 32'h10, 1'b1, 1'b0, 1'b0);
        chk("pos_sext", 64'(imm_sext), 64'h0000_7FFF);
        idle(1'b1);

        // Back-pressure: third beat must wait while two are held.
        step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hAAAA_0001, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0003, 32'h108, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        step(1'b1, 32'hAAAA_0003, 32'h108, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        step(1'b1, 32'hAAAA_0003, 32'h108, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0003, 32'h108, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush from the full state with a beat offered in the same cycle.
        step(1'b1, 32'hBBBB_0001, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0003, 32'h208, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'(NOP));
        chk("flush_ready", 64'(in_ready), 64'd1);
        idle(1'b1);

        // Counter saturation and clear-over-increment.
        step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hCCCC_0001, 32'h300, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        chk("cnt_saturated", 64'(stall_cnt), 64'd15);
        step(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        chk("cnt_cleared", 64'(stall_cnt), 64'd0);
        idle(1'b1);

        // Asynchronous reset between edges while full.
        step(1'b1, 32'hDDDD_0001, 32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDDDD_0002, 32'h404, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        #1 resetIF_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_instr", 64'(out_instr), 64'(NOP));
        chk("arst_out_pc", 64'(out_pc), 64'd0);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        sb.delete();
        model_cnt = 0;
        @(negedge reloj);
        resetIF_n = 1'b1;
        step(1'b1, 32'hEEEE_0001, 32'h500, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
